fetch_stage: RTL

Instruction-fetch stage sitting directly upstream of `InstMem`. It holds the program counter and drives the 8-bit instruction address. It captures the returned 32-bit instruction into an IF/ID pipeline register for the decode stage. It supports stall, branch/jump redirect with bubble insertion, and a start/halt control state machine.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/pc_counter.sv | 28 ++
 rtl/fetch_stage.sv | 95 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state encoding for the instruction-fetch stage
package fetch_pkg;

    localparam int          ADDR_W_DEF     = 8;
    localparam int          DATA_W_DEF     = 32;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE  = 2'd0;
    localparam fetch_state_t ST_FETCH = 2'd1;
    localparam fetch_state_t ST_HALT  = 2'd2;

endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program counter register with load, hold and wrapping increment
module pc_counter #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    // Load beats increment; with neither asserted the pc simply holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + STEP;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: pc, IF/ID register and start/halt control
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                PC_STEP    = 1,
    parameter logic [DATA_W-1:0] HALT_INSTR = DATA_W'(HALT_INSTR_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic              id_valid,
    output logic              busy,
    output logic              halted
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              is_halt;
    logic              pc_inc;

    assign is_halt = (imem_instr == HALT_INSTR);

    // The halt instruction is forwarded but the pc stays parked on it.
    assign pc_inc = (state == ST_FETCH) && !redirect_valid && !stall && !is_halt;

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (redirect_valid),
        .load_pc (redirect_pc),
        .inc     (pc_inc),
        .pc      (pc)
    );

    assign imem_addr = pc;
    assign busy      = (state == ST_FETCH);
    assign halted    = (state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            id_instr <= DATA_W'(NOP_INSTR);
            id_pc    <= '0;
            id_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    id_valid <= 1'b0;
                    if (!redirect_valid && start) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Redirect squashes the slot into a bubble but keeps the old id_pc.
                    if (redirect_valid) begin
                        id_instr <= DATA_W'(NOP_INSTR);
                        id_valid <= 1'b0;
                    end else if (!stall) begin
                        id_instr <= imem_instr;
                        id_pc    <= pc;
                        id_valid <= 1'b1;
                        if (is_halt) begin
                            state <= ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    id_valid <= 1'b0;
                    if (redirect_valid) begin
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    id_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
